// File: rtl/hdmi_tpg_timing.sv
// hdmi_tpg_timing: video timing generator with selectable test patterns.
// Outputs are registered and follow the counter state by one pixel clock.
module hdmi_tpg_timing #(
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter logic SYNC_POL = 1'b0
) (
    input  logic       PXLCLK_I,
    input  logic       RST_I,
    input  logic       DEN_TPG,
    input  logic [3:0] TPG_mode,
    output logic       HS_O,
    output logic       VS_O,
    output logic       DE_O,
    output logic [7:0] R_O,
    output logic [7:0] G_O,
    output logic [7:0] B_O,
    output logic       FRAME_O
);
    localparam logic [11:0] HA  = 12'(H_ACTIVE);
    localparam logic [11:0] VA  = 12'(V_ACTIVE);
    localparam logic [11:0] HT1 = 12'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [11:0] VT1 = 12'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [11:0] HS0 = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] HS1 = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [11:0] VS0 = 12'(V_ACTIVE + V_FP);
    localparam logic [11:0] VS1 = 12'(V_ACTIVE + V_FP + V_SYNC);

    logic [11:0] h_q, h_d, v_q, v_d;
    logic [7:0]  frame_cnt_q, frame_cnt_d;
    logic [3:0]  mode_q, mode_d;
    logic        hs_q, vs_q, de_q, frame_q;
    logic [23:0] rgb_q, pix;
    logic [2:0]  bar;
    logic        h_wrap, v_wrap, first, active, hs_on, vs_on, grid;

    assign h_wrap      = h_q == HT1;
    assign v_wrap      = v_q == VT1;
    assign first       = h_q == 12'd0 && v_q == 12'd0;
    assign active      = h_q < HA && v_q < VA;
    assign hs_on       = h_q >= HS0 && h_q < HS1;
    assign vs_on       = v_q >= VS0 && v_q < VS1;
    assign h_d         = h_wrap ? 12'd0 : h_q + 12'd1;
    assign v_d         = h_wrap ? (v_wrap ? 12'd0 : v_q + 12'd1) : v_q;
    assign frame_cnt_d = (h_wrap && v_wrap) ? frame_cnt_q + 8'd1 : frame_cnt_q;
    // The mode captured at (0,0) already governs that first pixel.
    assign mode_d      = first ? TPG_mode : mode_q;
    assign grid        = h_q == 12'd0 || h_q == HA - 12'd1 || v_q == 12'd0 || v_q == VA - 12'd1
                         || h_q[5:0] == 6'd0 || v_q[5:0] == 6'd0;

    always_comb begin
        bar = 3'd0;
        for (int k = 1; k < 8; k++) bar = bar + 3'(h_q >= 12'(k * H_ACTIVE / 8));
        case (mode_d)
            4'd1:    pix = 24'hFF0000;
            4'd2:    pix = 24'h00FF00;
            4'd3:    pix = 24'h0000FF;
            4'd4:    pix = 24'hFFFFFF;
            4'd6:    pix = {{8{~bar[1]}}, {8{~bar[2]}}, {8{~bar[0]}}};
            4'd7:    pix = {3{h_q[9:2]}};
            4'd8:    pix = {3{v_q[8:1]}};
            4'd9:    pix = {24{h_q[5] ^ v_q[5]}};
            4'd10:   pix = {24{grid}};
            4'd11:   pix = h_q[9:4] == frame_cnt_q[5:0] ? 24'hFFFFFF : 24'h000080;
            default: pix = 24'h000000;
        endcase
    end

    always_ff @(posedge PXLCLK_I) begin
        if (RST_I) begin
            h_q         <= 12'd0;
            v_q         <= 12'd0;
            frame_cnt_q <= 8'd0;
            mode_q      <= 4'd0;
            hs_q        <= ~SYNC_POL;
            vs_q        <= ~SYNC_POL;
            de_q        <= 1'b0;
            frame_q     <= 1'b0;
            rgb_q       <= 24'h000000;
        end else begin
            h_q         <= h_d;
            v_q         <= v_d;
            frame_cnt_q <= frame_cnt_d;
            mode_q      <= mode_d;
            hs_q        <= hs_on ? SYNC_POL : ~SYNC_POL;
            vs_q        <= vs_on ? SYNC_POL : ~SYNC_POL;
            de_q        <= active;
            frame_q     <= first;
            rgb_q       <= (active && DEN_TPG) ? pix : 24'h000000;
        end
    end

    assign HS_O    = hs_q;
    assign VS_O    = vs_q;
    assign DE_O    = de_q;
    assign FRAME_O = frame_q;
    assign R_O     = rgb_q[23:16];
    assign G_O     = rgb_q[15:8];
    assign B_O     = rgb_q[7:0];
endmodule

// File: tb/tb_hdmi_tpg_timing.sv
// tb_hdmi_tpg_timing: reduced-size timing with a position/frame based reference model.
module tb_hdmi_tpg_timing;
    localparam int   HA = 64, HFP = 4, HSY = 8, HBP = 4;
    localparam int   VA = 48, VFP = 2, VSY = 2, VBP = 3;
    localparam int   HT = HA + HFP + HSY + HBP;
    localparam int   VT = VA + VFP + VSY + VBP;
    localparam int   FT = HT * VT;
    localparam logic POL = 1'b0;

    logic       PXLCLK_I = 1'b0, RST_I = 1'b1, DEN_TPG = 1'b0;
    logic [3:0] TPG_mode = 4'd0;
    logic       HS_O, VS_O, DE_O, FRAME_O;
    logic [7:0] R_O, G_O, B_O;

    int errors = 0, checks = 0;
    int pos = 0, fcnt = 0, amode = 0, last_h = -1, last_v = -1;
    int cyc = 0, f_cyc = 0, de_cnt = 0, hs_fall = 0, vs_fall = 0;
    bit f_ok = 0, hs_ok = 0, vs_ok = 0;
    logic hs_prev = 1'b1, vs_prev = 1'b1;

    hdmi_tpg_timing #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP), .SYNC_POL(POL)
    ) dut (
        .PXLCLK_I(PXLCLK_I), .RST_I(RST_I), .DEN_TPG(DEN_TPG), .TPG_mode(TPG_mode),
        .HS_O(HS_O), .VS_O(VS_O), .DE_O(DE_O), .R_O(R_O), .G_O(G_O), .B_O(B_O),
        .FRAME_O(FRAME_O)
    );

    always #5 PXLCLK_I = ~PXLCLK_I;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [23:0] pix(input int m, input int x, input int y, input int f);
        int g;
        case (m)
            1: return 24'hFF0000;
            2: return 24'h00FF00;
            3: return 24'h0000FF;
            4: return 24'hFFFFFF;
            6: case (x / (HA / 8))
                   0: return 24'hFFFFFF;
                   1: return 24'hFFFF00;
                   2: return 24'h00FFFF;
                   3: return 24'h00FF00;
                   4: return 24'hFF00FF;
                   5: return 24'hFF0000;
                   6: return 24'h0000FF;
                   default: return 24'h000000;
               endcase
            7: begin g = (x / 4) % 256; return {3{8'(g)}}; end
            8: begin g = (y / 2) % 256; return {3{8'(g)}}; end
            9: return ((x / 32 + y / 32) % 2) ? 24'hFFFFFF : 24'h000000;
            10: return (x == 0 || x == HA - 1 || y == 0 || y == VA - 1 || x % 64 == 0 || y % 64 == 0)
                       ? 24'hFFFFFF : 24'h000000;
            11: return ((x / 16) % 64 == f % 64) ? 24'hFFFFFF : 24'h000080;
            default: return 24'h000000;
        endcase
    endfunction

    function automatic logic [23:0] rgb();
        return {R_O, G_O, B_O};
    endfunction

    task automatic step(input logic rst, input logic den, input logic [3:0] mode);
        logic [27:0] exp;
        int h, v, m;
        bit act;
        RST_I = rst; DEN_TPG = den; TPG_mode = mode;
        @(posedge PXLCLK_I);
        if (rst) begin
            exp = {~POL, ~POL, 2'b00, 24'h0};
            pos = 0; fcnt = 0; amode = 0;
        end else begin
            h = pos % HT; v = pos / HT;
            m = (pos == 0) ? int'(mode) : amode;
            act = h < HA && v < VA;
            exp = {(h >= HA + HFP && h < HA + HFP + HSY) ? POL : ~POL,
                   (v >= VA + VFP && v < VA + VFP + VSY) ? POL : ~POL,
                   act, pos == 0, (act && den) ? pix(m, h, v, fcnt) : 24'h0};
            amode = m; last_h = h; last_v = v;
            pos++;
            if (pos == FT) begin pos = 0; fcnt = (fcnt + 1) % 256; end
        end
        #1;
        cyc++;
        chk("out", {4'h0, HS_O, VS_O, DE_O, FRAME_O, R_O, G_O, B_O}, {4'h0, exp});
        if (rst) begin
            f_ok = 0; hs_ok = 0; vs_ok = 0;
        end else begin
            if (FRAME_O) begin
                if (f_ok) begin
                    chk("frame_period", cyc - f_cyc, FT);
                    chk("de_count", de_cnt, HA * VA);
                end
                f_cyc = cyc; de_cnt = 0; f_ok = 1;
            end
            de_cnt += int'(DE_O);
            if (HS_O == POL && hs_prev != POL) begin
                if (hs_ok) chk("hs_period", cyc - hs_fall, HT);
                hs_fall = cyc; hs_ok = 1;
            end
            if (HS_O != POL && hs_prev == POL && hs_ok) chk("hs_width", cyc - hs_fall, HSY);
            if (VS_O == POL && vs_prev != POL) begin vs_fall = cyc; vs_ok = 1; end
            if (VS_O != POL && vs_prev == POL && vs_ok) chk("vs_width", cyc - vs_fall, VSY * HT);
        end
        hs_prev = HS_O; vs_prev = VS_O;
        @(negedge PXLCLK_I);
    endtask

    task automatic go_to(input int h, input int v, input logic den, input logic [3:0] mode);
        int n = 0;
        do begin
            step(1'b0, den, mode);
            n++;
        end while (!(last_h == h && last_v == v) && n < 2 * FT);
        chk("goto_pos", 32'(last_v * 4096 + last_h), 32'(v * 4096 + h));
    endtask

    initial begin
        int rr;
        logic dd;
        logic [3:0] mm;
        @(negedge PXLCLK_I);
        repeat (3) step(1'b1, 1'b0, 4'd0);
        chk("rst_ctrl", {HS_O, VS_O, DE_O, FRAME_O}, 4'b1100);
        chk("rst_rgb", rgb(), 24'h0);
        // colour bars
        go_to(0, 0, 1'b1, 4'd6);  chk("bar_x0", rgb(), 24'hFFFFFF);
        chk("first_frame_pulse", {DE_O, FRAME_O}, 2'b11);
        go_to(7, 0, 1'b1, 4'd6);  chk("bar_x7", rgb(), 24'hFFFFFF);
        go_to(8, 0, 1'b1, 4'd6);  chk("bar_x8", rgb(), 24'hFFFF00);
        go_to(56, 0, 1'b1, 4'd6); chk("bar_x56", rgb(), 24'h000000);
        go_to(63, 0, 1'b1, 4'd6); chk("bar_x63", rgb(), 24'h000000);
        go_to(70, 0, 1'b1, 4'd6); chk("blank_rgb", {7'h0, DE_O, rgb()}, 32'h0);
        // mid-frame mode change
        go_to(0, 0, 1'b1, 4'd1);
        go_to(0, 10, 1'b1, 4'd1);
        go_to(5, 20, 1'b1, 4'd9);  chk("hold_red", rgb(), 24'hFF0000);
        go_to(0, 0, 1'b1, 4'd9);   chk("chk_0_0", rgb(), 24'h000000);
        go_to(32, 0, 1'b1, 4'd9);  chk("chk_32_0", rgb(), 24'hFFFFFF);
        go_to(32, 32, 1'b1, 4'd9); chk("chk_32_32", rgb(), 24'h000000);
        // pattern disabled, timing unaffected
        go_to(0, 0, 1'b0, 4'd4);
        go_to(10, 10, 1'b0, 4'd4); chk("den0", {7'h0, DE_O, rgb()}, {7'h0, 1'b1, 24'h0});
        go_to(0, 0, 1'b0, 4'd4);
        go_to(0, 0, 1'b1, 4'd4);
        // reset mid-frame
        go_to(30, 20, 1'b1, 4'd4);
        step(1'b1, 1'b1, 4'd4);
        chk("midrst_ctrl", {HS_O, VS_O, DE_O, FRAME_O}, 4'b1100);
        step(1'b0, 1'b1, 4'd4);
        chk("postrst_de_frame", {DE_O, FRAME_O}, 2'b11);
        chk("postrst_rgb", rgb(), 24'hFFFFFF);
        // moving bar over three frames
        step(1'b1, 1'b1, 4'd11);
        go_to(0, 0, 1'b1, 4'd11);  chk("mbar_f0_x0", rgb(), 24'hFFFFFF);
        go_to(16, 0, 1'b1, 4'd11); chk("mbar_f0_x16", rgb(), 24'h000080);
        go_to(16, 0, 1'b1, 4'd11); chk("mbar_f1_x16", rgb(), 24'hFFFFFF);
        go_to(32, 0, 1'b1, 4'd11); chk("mbar_f1_x32", rgb(), 24'h000080);
        go_to(32, 0, 1'b1, 4'd11); chk("mbar_f2_x32", rgb(), 24'hFFFFFF);
        go_to(0, 0, 1'b1, 4'd13);  chk("mode13_0_0", rgb(), 24'h000000);
        go_to(20, 20, 1'b1, 4'd13); chk("mode13_20_20", rgb(), 24'h000000);
        // randomized run against the model
        dd = 1'b1; mm = 4'($urandom_range(0, 15));
        for (int i = 0; i < 3 * FT; i++) begin
            if ($urandom_range(0, 63) == 0) mm = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 127) == 0) dd = ~dd;
            rr = ($urandom_range(0, 2999) == 0) ? 1 : 0;
            step(rr != 0, dd, mm);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
